// File: rtl/input_conditioner.sv
// input_conditioner: synchronize, debounce and qualify three active-low game keys
// Ports: clk/rst (async active-high); key_n[2:0] raw keys {left, jump, right};
// game_tick 60 Hz strobe consuming jump_req; move_left/move_right qualified moves;
// jump debounced jump level; jump_req latched press; any_input_level OR of keys.
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] key_n,
  input  logic       game_tick,
  output logic       move_left,
  output logic       move_right,
  output logic       jump,
  output logic       jump_req,
  output logic       any_input_level
);
  localparam logic [CNT_W-1:0] CMAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  typedef enum logic {IDLE, PENDING} state_t;
  logic [2:0] sync1_q, sync2_q, d_q, d_d, s;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic jprev_q, rise;
  state_t state_q, state_d;
  assign s = ~sync2_q;
  assign rise = d_q[1] & ~jprev_q;
  always_comb begin
    d_d = d_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (s[i] != d_q[i]) begin
        if (cnt_q[i] == CMAX) d_d[i] = s[i];
        else cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end
  // A fresh rising edge wins over consumption so a press coinciding with the tick is not lost.
  always_comb begin
    state_d = rise ? PENDING : (game_tick ? IDLE : state_q);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
      d_q <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      jprev_q <= 1'b0;
      state_q <= IDLE;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      d_q <= d_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      jprev_q <= d_q[1];
      state_q <= state_d;
    end
  end
  assign move_left = d_q[2] & ~d_q[0];
  assign move_right = d_q[0] & ~d_q[2];
  assign jump = d_q[1];
  assign any_input_level = |d_q;
  assign jump_req = state_q == PENDING;
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: scoreboard bench for input_conditioner with DEBOUNCE_CYCLES=4
module tb_input_conditioner;
  logic clk = 0, rst = 0, game_tick = 0;
  logic [2:0] key_n = 3'b111;
  logic move_left, move_right, jump, jump_req, any_input_level;
  int cyc = 0, checks = 0, failures = 0;
  typedef struct {int cyc; bit is_cnt; logic [4:0] v; string n;} exp_t;
  exp_t q[$];
  exp_t m;
  input_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .key_n(key_n), .game_tick(game_tick),
    .move_left(move_left), .move_right(move_right), .jump(jump),
    .jump_req(jump_req), .any_input_level(any_input_level)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  wire [4:0] outs = {move_left, move_right, jump, jump_req, any_input_level};
  task automatic check(string n, logic [4:0] act, logic [4:0] e);
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s: got %b expected %b (cyc %0d)", n, act, e, cyc);
    end
  endtask
  task automatic expect_at(int k, logic [4:0] v, string n, bit is_cnt = 0);
    exp_t e = '{k, is_cnt, v, n};
    int i = 0;
    while (i < q.size() && q[i].cyc <= k) i++;
    q.insert(i, e);
  endtask
  task automatic go(int k);
    while (cyc < k) @(negedge clk);
  endtask
  always @(negedge clk)
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m = q.pop_front();
      check(m.n, m.is_cnt ? 5'(dut.cnt_q[2]) : outs, m.v);
    end
  initial begin
    int c;
    #1 rst = 1;
    #2 check("reset_hold", outs, 5'b0);
    @(negedge clk); @(negedge clk);
    rst = 0; c = cyc;
    expect_at(c + 1, 5'b0, "post_reset");
    go(c + 3); c = cyc;
    key_n[0] = 0;
    expect_at(c + 5, 5'b00000, "right_pre");
    expect_at(c + 6, 5'b01001, "right_on");
    go(c + 8); key_n[0] = 1;
    expect_at(c + 13, 5'b01001, "right_hold");
    expect_at(c + 14, 5'b00000, "right_off");
    go(c + 16); c = cyc;
    key_n[2] = 0;
    go(c + 3); key_n[2] = 1;
    expect_at(c + 5, 5'd3, "glitch_cnt_peak", 1);
    expect_at(c + 6, 5'd0, "glitch_cnt_clear", 1);
    expect_at(c + 6, 5'b0, "glitch_ml");
    expect_at(c + 9, 5'b0, "glitch_ml_late");
    go(c + 10); c = cyc;
    key_n = 3'b010;
    expect_at(c + 6, 5'b00001, "conflict_both");
    go(c + 8); key_n = 3'b011;
    expect_at(c + 13, 5'b00001, "conflict_pre_left");
    expect_at(c + 14, 5'b10001, "conflict_left");
    go(c + 16); key_n = 3'b111;
    expect_at(c + 21, 5'b10001, "left_hold");
    expect_at(c + 22, 5'b00000, "left_off");
    go(c + 24); c = cyc;
    key_n[1] = 0;
    expect_at(c + 6, 5'b00101, "jump_level");
    expect_at(c + 7, 5'b00111, "jump_req_set");
    expect_at(c + 20, 5'b00111, "jump_req_hold");
    go(c + 26); game_tick = 1;
    expect_at(c + 26, 5'b00111, "jump_req_tick_cycle");
    expect_at(c + 27, 5'b00101, "jump_req_consumed");
    go(c + 27); game_tick = 0;
    expect_at(c + 40, 5'b00101, "jump_held_no_rearm");
    go(c + 40); key_n[1] = 1;
    expect_at(c + 45, 5'b00101, "jump_release_pre");
    expect_at(c + 46, 5'b00000, "jump_released");
    go(c + 48); c = cyc;
    key_n[1] = 0;
    expect_at(c + 7, 5'b00111, "sim_pending");
    go(c + 8); key_n[1] = 1;
    expect_at(c + 14, 5'b00010, "sim_pending_released");
    go(c + 16); key_n[1] = 0;
    go(c + 22); game_tick = 1;
    expect_at(c + 22, 5'b00111, "sim_tick_cycle");
    expect_at(c + 23, 5'b00111, "sim_kept_pending");
    go(c + 23); game_tick = 0;
    expect_at(c + 30, 5'b00111, "sim_still_pending");
    go(c + 32); c = cyc;
    key_n = 3'b100;
    go(c + 4);
    check("pre_rst_outs", outs, 5'b00111);
    check("pre_rst_cnt", 5'(dut.cnt_q[0]), 5'd2);
    #2 rst = 1; key_n = 3'b111;
    #1 check("rst_async_outs", outs, 5'b0);
    check("rst_async_cnt", 5'(dut.cnt_q[0]), 5'd0);
    @(negedge clk); @(negedge clk);
    rst = 0; c = cyc;
    expect_at(c + 1, 5'b0, "after_rst_1");
    expect_at(c + 8, 5'b0, "after_rst_8");
    expect_at(c + 12, 5'b0, "after_rst_12");
    for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      failures++;
      $display("FAIL scoreboard_drain: pending %0d expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
